pwm_capture: RTL

Receive-side counterpart of the team's PWM generator. It samples an asynchronous PWM input and measures each full period (rising edge to rising edge) and the high time within it, counted in sample ticks. Results are published with a one-cycle valid strobe. A timeout flags a stuck-high or stuck-low input. It sits beside PWM outputs for loopback checking, or on external PWM inputs such as fan tach lines and servo feedback.

---
 rtl/pwm_capture_pkg.sv | 19 +
 rtl/pwm_capture_sync_edge.sv | 43 ++++
 rtl/pwm_capture.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared types and defaults for the PWM capture block.
package pwm_capture_pkg;

   typedef enum logic {
      WAIT_RISE = 1'b0,
      MEASURE   = 1'b1
   } cap_state_e;

   localparam int DEFAULT_W          = 16;
   localparam int DEFAULT_TIMER_BITS = 15;

   // All-ones counter limit for a w-bit counter.
   function automatic logic [31:0] cnt_max(input int w);
      logic [31:0] one_v;
      one_v = 32'd1;
      return (one_v << w) - 32'd1;
   endfunction

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchronizer for the PWM input plus tick-gated previous-sample
// register; rise fires on a tick whose sample is high after a low one.
module pwm_sync_edge #(
   parameter logic PREV_RST = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic din,
   output logic s,
   output logic rise
);

   logic sync1_r;
   logic sync2_r;
   logic prev_r;

   // Metastability guard, runs every clk independent of the tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= din;
         sync2_r <= sync1_r;
      end
   end

   // Previous sample only advances on ticks so edges are seen in tick time.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_r <= PREV_RST;
      end else if (tick) begin
         prev_r <= sync2_r;
      end else begin
         prev_r <= prev_r;
      end
   end

   assign s    = sync2_r;
   assign rise = tick & sync2_r & ~prev_r;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM period and high time in prescaled sample ticks, with a
// timeout strobe for inputs that stop toggling.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int W          = DEFAULT_W,
   parameter int TIMER_BITS = DEFAULT_TIMER_BITS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [TIMER_BITS-1:0] PRESCALE_FINAL,
   input  logic                  pwm_in,
   output logic [W-1:0]          period,
   output logic [W-1:0]          high_time,
   output logic                  valid,
   output logic                  timeout,
   output logic                  level
);

   localparam logic [W-1:0]          CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0]          CNT_ONE = {{(W-1){1'b0}}, 1'b1};
   localparam logic [TIMER_BITS-1:0] PRE_ONE = {{(TIMER_BITS-1){1'b0}}, 1'b1};

   logic [TIMER_BITS-1:0] pre_cnt_r;
   logic                  tick_s;
   logic                  s_s;
   logic                  rise_s;

   cap_state_e            state_r;
   cap_state_e            state_nx_s;
   logic [W-1:0]          per_cnt_r;
   logic [W-1:0]          per_cnt_nx_s;
   logic [W-1:0]          high_cnt_r;
   logic [W-1:0]          high_cnt_nx_s;
   logic [W-1:0]          period_nx_s;
   logic [W-1:0]          high_nx_s;
   logic                  valid_nx_s;
   logic                  timeout_nx_s;
   logic                  level_nx_s;

   assign tick_s = (pre_cnt_r == PRESCALE_FINAL);

   // Prescaler; the >= wrap absorbs a compare value lowered below the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt_r <= '0;
      end else if (pre_cnt_r >= PRESCALE_FINAL) begin
         pre_cnt_r <= '0;
      end else begin
         pre_cnt_r <= pre_cnt_r + PRE_ONE;
      end
   end

   pwm_sync_edge #(
      .PREV_RST(1'b1)
   ) u_sync_edge (
      .clk   (clk),
      .reset (reset),
      .tick  (tick_s),
      .din   (pwm_in),
      .s     (s_s),
      .rise  (rise_s)
   );

   // Next-state and result logic; per_cnt also times the wait for a first rise.
   always_comb begin
      state_nx_s    = state_r;
      per_cnt_nx_s  = per_cnt_r;
      high_cnt_nx_s = high_cnt_r;
      period_nx_s   = period;
      high_nx_s     = high_time;
      valid_nx_s    = 1'b0;
      timeout_nx_s  = 1'b0;
      level_nx_s    = level;
      if (tick_s) begin
         if (rise_s) begin
            case (state_r)
               MEASURE: begin
                  period_nx_s = per_cnt_r;
                  high_nx_s   = high_cnt_r;
                  valid_nx_s  = 1'b1;
               end
               WAIT_RISE: begin
                  valid_nx_s = 1'b0;
               end
               default: begin
                  valid_nx_s = 1'b0;
               end
            endcase
            per_cnt_nx_s  = CNT_ONE;
            high_cnt_nx_s = CNT_ONE;
            state_nx_s    = MEASURE;
         end else if (per_cnt_r == CNT_MAX) begin
            timeout_nx_s = 1'b1;
            level_nx_s   = s_s;
            per_cnt_nx_s = CNT_ONE;
            state_nx_s   = WAIT_RISE;
         end else begin
            per_cnt_nx_s = per_cnt_r + CNT_ONE;
            if (state_r == MEASURE) begin
               high_cnt_nx_s = high_cnt_r + {{(W-1){1'b0}}, s_s};
            end else begin
               high_cnt_nx_s = high_cnt_r;
            end
         end
      end else begin
         state_nx_s = state_r;
      end
   end

   // State, counters and published results.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= WAIT_RISE;
         per_cnt_r  <= CNT_ONE;
         high_cnt_r <= '0;
         period     <= '0;
         high_time  <= '0;
         valid      <= 1'b0;
         timeout    <= 1'b0;
         level      <= 1'b0;
      end else begin
         state_r    <= state_nx_s;
         per_cnt_r  <= per_cnt_nx_s;
         high_cnt_r <= high_cnt_nx_s;
         period     <= period_nx_s;
         high_time  <= high_nx_s;
         valid      <= valid_nx_s;
         timeout    <= timeout_nx_s;
         level      <= level_nx_s;
      end
   end

endmodule
